// File: rtl/datapath_seq.sv
// Multi-cycle controller for the 8x16 register file / A-B-C / shifter / ALU datapath.
// Decodes a latched 16-bit instruction and steps one control state per cycle.
module datapath_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic        bad_instr
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
  } ctrl_t;

  function automatic logic f_movi(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
  endfunction

  function automatic logic f_movr(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
  endfunction

  function automatic logic f_alu(input logic [15:0] ir);
    return (ir[15:13] == 3'b101);
  endfunction

  function automatic logic f_mvn(input logic [15:0] ir);
    return f_alu(ir) && (ir[12:11] == 2'b11);
  endfunction

  function automatic logic f_cmp(input logic [15:0] ir);
    return f_alu(ir) && (ir[12:11] == 2'b01);
  endfunction

  // Moore control word for a given state and instruction.
  function automatic ctrl_t ctrl_of(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT: c.w = 1'b1;
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_ALU: begin
        if (f_movr(ir) || f_mvn(ir)) c.asel = 1'b1;
        else                         c.asel = 1'b0;
        if (f_cmp(ir)) c.loads = 1'b1;
        else           c.loadc = 1'b1;
      end
      S_WRITE_REG: begin
        c.writenum = ir[7:5];
        c.vsel     = 2'b00;
        c.write    = 1'b1;
      end
      S_WRITE_IMM: begin
        c.writenum = ir[10:8];
        c.vsel     = 2'b01;
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_ir;
  logic [15:0] w_ir_next;
  logic        r_bad;
  logic        w_bad_next;
  ctrl_t       r_ctrl;

  // Next-state, next-IR and sticky illegal-flag logic.
  always_comb begin
    w_state_next = r_state;
    w_bad_next   = r_bad;
    if (load && (r_state == S_WAIT)) w_ir_next = in;
    else                             w_ir_next = r_ir;
    case (r_state)
      S_WAIT: begin
        if (s) w_state_next = S_DECODE;
        else   w_state_next = S_WAIT;
      end
      S_DECODE: begin
        if (f_movi(r_ir))                     w_state_next = S_WRITE_IMM;
        else if (f_movr(r_ir) || f_mvn(r_ir)) w_state_next = S_GET_B;
        else if (f_alu(r_ir))                 w_state_next = S_GET_A;
        else                                  w_state_next = S_WAIT;
        if (f_movi(r_ir) || f_movr(r_ir) || f_alu(r_ir)) w_bad_next = 1'b0;
        else                                             w_bad_next = 1'b1;
      end
      S_GET_A: w_state_next = S_GET_B;
      S_GET_B: w_state_next = S_ALU;
      S_ALU: begin
        if (f_cmp(r_ir)) w_state_next = S_WAIT;
        else             w_state_next = S_WRITE_REG;
      end
      S_WRITE_REG: w_state_next = S_WAIT;
      S_WRITE_IMM: w_state_next = S_WAIT;
      default:     w_state_next = S_WAIT;
    endcase
  end

  // The control word is registered from the next state so it always equals ctrl_of(r_state, r_ir).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
      r_bad   <= 1'b0;
      r_ctrl  <= ctrl_of(S_WAIT, 16'h0000);
    end else begin
      r_state <= w_state_next;
      r_ir    <= w_ir_next;
      r_bad   <= w_bad_next;
      r_ctrl  <= ctrl_of(w_state_next, w_ir_next);
    end
  end

  assign w         = r_ctrl.w;
  assign readnum   = r_ctrl.readnum;
  assign writenum  = r_ctrl.writenum;
  assign write     = r_ctrl.write;
  assign vsel      = r_ctrl.vsel;
  assign loada     = r_ctrl.loada;
  assign loadb     = r_ctrl.loadb;
  assign loadc     = r_ctrl.loadc;
  assign loads     = r_ctrl.loads;
  assign asel      = r_ctrl.asel;
  assign bsel      = 1'b0;
  assign shift     = r_ir[4:3];
  assign ALUop     = r_ir[12:11];
  assign sximm8    = {{8{r_ir[7]}}, r_ir[7:0]};
  assign bad_instr = r_bad;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed ISA cases plus random instructions checked against a
// per-instruction expected control trace built from the instruction-class rules.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, bad_instr;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;

  datapath_seq dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .bad_instr(bad_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   lat_tab[7] = '{2, 4, 4, 5, 4, 5, 1};

  function automatic exp_t obs();
    exp_t e;
    e.w = w; e.readnum = readnum; e.writenum = writenum; e.write = write;
    e.vsel = vsel; e.loada = loada; e.loadb = loadb; e.loadc = loadc;
    e.loads = loads; e.asel = asel;
    return e;
  endfunction

  // 0 MOVimm, 1 MOVreg, 2 MVN, 3 ADD, 4 CMP, 5 AND, 6 illegal
  function automatic int kind(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: return 0;
      5'b110_00: return 1;
      5'b101_11: return 2;
      5'b101_00: return 3;
      5'b101_01: return 4;
      5'b101_10: return 5;
      default:   return 6;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic build_trace(input logic [15:0] ir);
    exp_t e;
    int   k;
    k = kind(ir);
    q.delete();
    e = '0; q.push_back(e);
    if (k == 0) begin
      e = '0; e.writenum = ir[10:8]; e.vsel = 2'b01; e.write = 1'b1; q.push_back(e);
    end else if (k <= 5) begin
      if (k >= 3) begin
        e = '0; e.readnum = ir[10:8]; e.loada = 1'b1; q.push_back(e);
      end
      e = '0; e.readnum = ir[2:0]; e.loadb = 1'b1; q.push_back(e);
      e = '0; e.asel = (k <= 2); e.loadc = (k != 4); e.loads = (k == 4); q.push_back(e);
      if (k != 4) begin
        e = '0; e.writenum = ir[7:5]; e.write = 1'b1; q.push_back(e);
      end
    end
    e = '0; e.w = 1'b1; q.push_back(e);
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic mid_load);
    int          lows;
    logic [15:0] sx;
    build_trace(ir);
    lows = 0;
    @(negedge clk);
    in = ir; load = 1'b1; s = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        s = 1'b0; load = mid_load; in = 16'($urandom);
      end else begin
        load = 1'b0;
      end
      chk($sformatf("step%0d_%h", k, ir), 32'(obs()), 32'(q[k]));
      if (w === 1'b0) lows++;
    end
    chk($sformatf("wlow_%h", ir), 32'(lows), 32'(lat_tab[kind(ir)]));
    chk($sformatf("bad_%h", ir), 32'(bad_instr), 32'(kind(ir) == 6));
    sx = 16'($signed(ir[7:0]));
    chk($sformatf("shift_%h", ir), 32'(shift), 32'(ir[4:3]));
    chk($sformatf("aluop_%h", ir), 32'(ALUop), 32'(ir[12:11]));
    chk($sformatf("sximm8_%h", ir), 32'(sximm8), 32'(sx));
    chk($sformatf("bsel_%h", ir), 32'(bsel), 32'(0));
  endtask

  initial begin
    exp_t        e_wait;
    logic [15:0] ir;
    e_wait = '0; e_wait.w = 1'b1;
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'(obs()), 32'(e_wait));
    chk("reset_bad", 32'(bad_instr), 32'(0));
    chk("reset_ir", 32'({shift, ALUop, sximm8}), 32'(0));
    reset = 1'b0;

    // Reset arriving during GET_B of an ADD
    @(negedge clk); in = 16'hA2A5; load = 1'b1; s = 1'b1;
    @(negedge clk); s = 1'b0; load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("getb_loadb", 32'({loadb, readnum}), 32'({1'b1, 3'd5}));
    reset = 1'b1;
    #1;
    chk("async_reset", 32'(obs()), 32'(e_wait));
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(obs()), 32'(e_wait));
      chk("post_reset_ir", 32'({shift, ALUop, sximm8}), 32'(0));
    end

    run_instr(16'hD0F7, 1'b0);
    chk("movi_sximm8", 32'(sximm8), 32'(16'hFFF7));
    run_instr(16'hA2A5, 1'b0);
    run_instr(16'hA93A, 1'b0);
    run_instr(16'hB803, 1'b0);
    run_instr(16'hC0E1, 1'b0);
    run_instr(16'hE000, 1'b0);
    run_instr(16'hA2A5, 1'b1);

    // s held high: same IR re-executes from the first WAIT cycle
    build_trace(16'hD0F7);
    @(negedge clk); in = 16'hD0F7; load = 1'b1; s = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("b2b_dec1", 32'(obs()), 32'(q[0]));
    @(negedge clk); chk("b2b_imm1", 32'(obs()), 32'(q[1]));
    @(negedge clk); chk("b2b_wait", 32'(obs()), 32'(q[2]));
    @(negedge clk); chk("b2b_dec2", 32'(obs()), 32'(q[0]));
    s = 1'b0;
    @(negedge clk); chk("b2b_imm2", 32'(obs()), 32'(q[1]));
    @(negedge clk); chk("b2b_end", 32'(obs()), 32'(q[2]));

    for (int n = 0; n < 60; n++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 7) ir[15:13] = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
      run_instr(ir, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
